// File: rtl/key_search_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_search_pkg
// Brief    : Shared types and constants for the RC4 key-search arbiter.
// Revision : 1.0
// ============================================================================
package key_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2,
        FAILED = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK         = 7'h7F;
    localparam logic [6:0] SEG_DASH          = 7'h3F;
    localparam int         DEFAULT_KEY_WIDTH = 24;
    localparam int         DEFAULT_NUM_CORES = 4;

endpackage
`default_nettype wire

// File: rtl/key_search_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : key_search_arbiter_if
// Brief    : Core-status, control and display bundle around the arbiter.
// Revision : 1.0
// ============================================================================
interface key_search_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = 24
);
    localparam int WIN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                           start;
    logic [NUM_CORES-1:0]           core_finish;
    logic [NUM_CORES-1:0]           core_found;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic                           outer_finish;
    logic                           busy;
    logic                           key_valid;
    logic [KEY_WIDTH-1:0]           key_out;
    logic [WIN_W-1:0]               winner;
    logic                           search_failed;
    logic [41:0]                    hex_out;

    // Arbiter side
    modport slave (
        input  start, core_finish, core_found, core_key,
        output outer_finish, busy, key_valid, key_out, winner, search_failed, hex_out
    );

    // Core / controller side
    modport master (
        output start, core_finish, core_found, core_key,
        input  outer_finish, busy, key_valid, key_out, winner, search_failed, hex_out
    );
endinterface
`default_nettype wire

// File: rtl/hex_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_decoder
// Brief    : Nibble to active-low 7-segment glyph (bit 0 = segment a).
// Revision : 1.0
// ============================================================================
module hex_seg_decoder (
    input  wire logic [3:0] nibble,
    output logic      [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/key_search_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : key_search_arbiter
// Brief    : Picks the first RC4 core reporting a valid key, or flags failure.
// Revision : 1.0
// ============================================================================
module key_search_arbiter
    import key_search_pkg::*;
#(
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    key_search_arbiter_if.slave    bus
);
    localparam int WIN_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t                 r_state;
    logic [NUM_CORES-1:0]   r_done_mask;
    logic                   r_busy;
    logic                   r_key_valid;
    logic                   r_search_failed;
    logic                   r_outer_finish;
    logic [KEY_WIDTH-1:0]   r_key_out;
    logic [WIN_W-1:0]       r_winner;
    logic [41:0]            r_hex;

    logic [NUM_CORES-1:0]   w_hit;
    logic                   w_all_done;
    logic [WIN_W-1:0]       w_win_idx;
    logic [KEY_WIDTH-1:0]   w_win_key;
    logic [41:0]            w_hex_key;

    assign w_hit      = bus.core_finish & bus.core_found;
    assign w_all_done = &(r_done_mask | bus.core_finish);

    // Descending scan so the lowest set index is the one left standing
    always_comb begin
        w_win_idx = '0;
        w_win_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win_idx = WIN_W'(i);
                w_win_key = bus.core_key[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_done_mask     <= '0;
            r_busy          <= 1'b0;
            r_key_valid     <= 1'b0;
            r_search_failed <= 1'b0;
            r_outer_finish  <= 1'b0;
            r_key_out       <= '0;
            r_winner        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state     <= SEARCH;
                        r_busy      <= 1'b1;
                        r_done_mask <= '0;
                    end
                end
                SEARCH: begin
                    r_done_mask <= r_done_mask | bus.core_finish;
                    if (|w_hit) begin
                        r_state        <= FOUND;
                        r_busy         <= 1'b0;
                        r_key_valid    <= 1'b1;
                        r_outer_finish <= 1'b1;
                        r_key_out      <= w_win_key;
                        r_winner       <= w_win_idx;
                    end else if (w_all_done) begin
                        r_state         <= FAILED;
                        r_busy          <= 1'b0;
                        r_search_failed <= 1'b1;
                        r_outer_finish  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    for (genvar d = 0; d < 6; d++) begin : g_digit
        hex_seg_decoder u_dec (
            .nibble (r_key_out[d*4 +: 4]),
            .seg    (w_hex_key[d*7 +: 7])
        );
    end

    // Display follows the registered state, so it trails the decision by a cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex <= {6{SEG_BLANK}};
        end else begin
            case (r_state)
                FOUND:   r_hex <= w_hex_key;
                FAILED:  r_hex <= {6{SEG_DASH}};
                default: r_hex <= {6{SEG_BLANK}};
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.key_valid     = r_key_valid;
    assign bus.search_failed = r_search_failed;
    assign bus.outer_finish  = r_outer_finish;
    assign bus.key_out       = r_key_out;
    assign bus.winner        = r_winner;
    assign bus.hex_out       = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_key_search_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_search_arbiter
// Brief    : Directed self-checking bench for key_search_arbiter.
// Revision : 1.0
// ============================================================================
module tb_key_search_arbiter;
    localparam int NC = 4;
    localparam int KW = 24;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    key_search_arbiter_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) bus ();

    key_search_arbiter #(.NUM_CORES(NC), .KEY_WIDTH(KW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start       = 1'b0;
        bus.core_finish = '0;
        bus.core_found  = '0;
        bus.core_key    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse(input logic [NC-1:0] fin, input logic [NC-1:0] fnd);
        bus.core_finish = fin;
        bus.core_found  = fnd;
        tick();
        bus.core_finish = '0;
        bus.core_found  = '0;
    endtask

    localparam logic [41:0] HEX_BLANK = {6{7'h7F}};
    localparam logic [41:0] HEX_DASH  = {6{7'h3F}};
    // digits 5..0 = 0,A,1,B,2,C
    localparam logic [41:0] HEX_0A1B2C = {7'h40, 7'h08, 7'h79, 7'h03, 7'h24, 7'h46};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        clear_inputs();
        tick();
        tick();

        // Reset values
        chk("rst_busy",   64'(bus.busy),          64'd0);
        chk("rst_valid",  64'(bus.key_valid),     64'd0);
        chk("rst_failed", 64'(bus.search_failed), 64'd0);
        chk("rst_outer",  64'(bus.outer_finish),  64'd0);
        chk("rst_key",    64'(bus.key_out),       64'd0);
        chk("rst_winner", 64'(bus.winner),        64'd0);
        chk("rst_hex",    64'(bus.hex_out),       64'(HEX_BLANK));
        reset_n = 1'b1;

        // Single hit on core 2
        do_start();
        chk("t1_busy", 64'(bus.busy), 64'd1);
        bus.core_key[2*KW +: KW] = 24'h0A1B2C;
        bus.core_key[0*KW +: KW] = 24'hFFFFFF;
        pulse(4'b0100, 4'b0100);
        chk("t1_valid",  64'(bus.key_valid),    64'd1);
        chk("t1_winner", 64'(bus.winner),       64'd2);
        chk("t1_key",    64'(bus.key_out),      64'h0A1B2C);
        chk("t1_outer",  64'(bus.outer_finish), 64'd1);
        chk("t1_busy0",  64'(bus.busy),         64'd0);
        chk("t1_hex_lag", 64'(bus.hex_out),     64'(HEX_BLANK));
        bus.core_key = '0;
        tick();
        chk("t1_hex", 64'(bus.hex_out), 64'(HEX_0A1B2C));
        // Terminal: start and further hits ignored
        bus.start = 1'b1;
        bus.core_key[0*KW +: KW] = 24'h123456;
        pulse(4'b0001, 4'b0001);
        bus.start = 1'b0;
        chk("t1_term_key",  64'(bus.key_out), 64'h0A1B2C);
        chk("t1_term_busy", 64'(bus.busy),    64'd0);

        // Simultaneous hits on cores 1 and 3
        do_reset();
        do_start();
        bus.core_key[1*KW +: KW] = 24'h111111;
        bus.core_key[3*KW +: KW] = 24'h333333;
        pulse(4'b1010, 4'b1010);
        chk("t2_winner", 64'(bus.winner),  64'd1);
        chk("t2_key",    64'(bus.key_out), 64'h111111);

        // All cores exhausted on separate cycles
        do_reset();
        do_start();
        pulse(4'b0001, 4'b0000);
        tick();
        pulse(4'b0010, 4'b0000);
        pulse(4'b0100, 4'b0000);
        tick();
        chk("t3_not_yet", 64'(bus.search_failed), 64'd0);
        chk("t3_busy",    64'(bus.busy),          64'd1);
        pulse(4'b1000, 4'b0000);
        chk("t3_failed", 64'(bus.search_failed), 64'd1);
        chk("t3_outer",  64'(bus.outer_finish),  64'd1);
        chk("t3_valid",  64'(bus.key_valid),     64'd0);
        tick();
        chk("t3_hex", 64'(bus.hex_out), 64'(HEX_DASH));

        // Hit on the edge that completes the mask; found without finish ignored
        do_reset();
        do_start();
        pulse(4'b0111, 4'b0000);
        pulse(4'b0000, 4'b1000);
        chk("t4_found_only", 64'(bus.key_valid), 64'd0);
        chk("t4_busy",       64'(bus.busy),      64'd1);
        bus.core_key[3*KW +: KW] = 24'hABCDEF;
        pulse(4'b1000, 4'b1000);
        chk("t4_winner", 64'(bus.winner),        64'd3);
        chk("t4_key",    64'(bus.key_out),       64'hABCDEF);
        chk("t4_failed", 64'(bus.search_failed), 64'd0);
        chk("t4_valid",  64'(bus.key_valid),     64'd1);

        // Activity before start is ignored
        do_reset();
        bus.core_key[0*KW +: KW] = 24'h000ABC;
        pulse(4'b0001, 4'b0001);
        chk("t5_idle_valid", 64'(bus.key_valid),    64'd0);
        chk("t5_idle_busy",  64'(bus.busy),         64'd0);
        chk("t5_idle_outer", 64'(bus.outer_finish), 64'd0);
        do_start();
        pulse(4'b0001, 4'b0001);
        chk("t5_winner", 64'(bus.winner),    64'd0);
        chk("t5_valid",  64'(bus.key_valid), 64'd1);
        chk("t5_key",    64'(bus.key_out),   64'h000ABC);
        // Asynchronous reset from FOUND
        #2 reset_n = 1'b0;
        #1;
        chk("t5_arst_outer", 64'(bus.outer_finish), 64'd0);
        chk("t5_arst_valid", 64'(bus.key_valid),    64'd0);
        chk("t5_arst_key",   64'(bus.key_out),      64'd0);
        tick();
        reset_n = 1'b1;

        // Asynchronous reset mid-search, then hit without start
        do_start();
        chk("t6_busy", 64'(bus.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_arst_busy",  64'(bus.busy),         64'd0);
        chk("t6_arst_outer", 64'(bus.outer_finish), 64'd0);
        chk("t6_arst_hex",   64'(bus.hex_out),      64'(HEX_BLANK));
        tick();
        reset_n = 1'b1;
        bus.core_key[2*KW +: KW] = 24'h555555;
        pulse(4'b0100, 4'b0100);
        chk("t6_no_resp_valid", 64'(bus.key_valid), 64'd0);
        chk("t6_no_resp_busy",  64'(bus.busy),      64'd0);
        chk("t6_no_resp_key",   64'(bus.key_out),   64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
